// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the dual-issue instruction fetch queue.
// An entry is one {pc, inst} pair packed into a 64-bit word.
package inst_fetch_queue_pkg;

    localparam int IFQ_DEPTH = 8;
    localparam int INST_ADDR_W = 32;
    localparam int INST_W = 32;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } ifq_entry_t;

    // Sum of two one-bit valid flags (0, 1 or 2).
    function automatic logic [1:0] slot_count(input logic a, input logic b);
        slot_count = {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Circular instruction buffer between fetch and decode. Accepts up to two pairs
// per cycle, presents the two oldest to decode, and flushes in one cycle.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push_valid_1,
    input  logic [INST_ADDR_W-1:0] push_pc_1,
    input  logic [INST_W-1:0]      push_inst_1,
    input  logic                   push_valid_2,
    input  logic [INST_ADDR_W-1:0] push_pc_2,
    input  logic [INST_W-1:0]      push_inst_2,
    input  logic                   id_stall,
    output logic                   full_o,
    output logic                   id_valid_1,
    output logic [INST_ADDR_W-1:0] id_pc_1,
    output logic [INST_W-1:0]      id_inst_1,
    output logic                   id_valid_2,
    output logic [INST_ADDR_W-1:0] id_pc_2,
    output logic [INST_W-1:0]      id_inst_2
);

    localparam logic [PTR_W:0]   FULL_THRESH = (PTR_W + 1)'(DEPTH - 2);
    localparam logic [PTR_W:0]   CNT_ONE     = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_TWO     = (PTR_W + 1)'(2);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    ifq_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;

    logic             full_s;
    logic             valid_1_s;
    logic             valid_2_s;
    logic [PTR_W-1:0] head_1_s;
    logic [PTR_W-1:0] tail_1_s;
    logic             wr_1_en_s;
    logic             wr_2_en_s;
    logic [PTR_W-1:0] wr_2_ptr_s;
    logic [1:0]       push_n_s;
    logic [1:0]       pop_n_s;

    // Occupancy flags; gated by rst so outputs read empty before the first edge.
    always_comb begin
        full_s    = 1'b0;
        valid_1_s = 1'b0;
        valid_2_s = 1'b0;
        if (rst) begin
            full_s    = 1'b0;
            valid_1_s = 1'b0;
            valid_2_s = 1'b0;
        end else begin
            full_s    = (count_r > FULL_THRESH);
            valid_1_s = (count_r >= CNT_ONE);
            valid_2_s = (count_r >= CNT_TWO);
        end
    end

    assign full_o   = full_s;
    assign head_1_s = head_r + PTR_ONE;
    assign tail_1_s = tail_r + PTR_ONE;

    // Decode-side view of the two oldest entries; invalid slots read as zero.
    always_comb begin
        id_valid_1 = valid_1_s;
        id_valid_2 = valid_2_s;
        id_pc_1    = 32'h0000_0000;
        id_inst_1  = 32'h0000_0000;
        id_pc_2    = 32'h0000_0000;
        id_inst_2  = 32'h0000_0000;
        if (valid_1_s) begin
            id_pc_1   = mem_r[head_r].pc;
            id_inst_1 = mem_r[head_r].inst;
        end else begin
            id_pc_1   = 32'h0000_0000;
            id_inst_1 = 32'h0000_0000;
        end
        if (valid_2_s) begin
            id_pc_2   = mem_r[head_1_s].pc;
            id_inst_2 = mem_r[head_1_s].inst;
        end else begin
            id_pc_2   = 32'h0000_0000;
            id_inst_2 = 32'h0000_0000;
        end
    end

    // Push acceptance with compaction: slot 2 lands at tail when slot 1 is empty.
    always_comb begin
        wr_1_en_s  = 1'b0;
        wr_2_en_s  = 1'b0;
        wr_2_ptr_s = tail_r;
        if (!full_s && !flush) begin
            wr_1_en_s = push_valid_1;
            wr_2_en_s = push_valid_2;
        end else begin
            wr_1_en_s = 1'b0;
            wr_2_en_s = 1'b0;
        end
        if (push_valid_1) begin
            wr_2_ptr_s = tail_1_s;
        end else begin
            wr_2_ptr_s = tail_r;
        end
        push_n_s = slot_count(wr_1_en_s, wr_2_en_s);
    end

    // Decode consumes every valid slot unless stalled or flushing.
    always_comb begin
        pop_n_s = 2'd0;
        if (!id_stall && !flush) begin
            pop_n_s = slot_count(valid_1_s, valid_2_s);
        end else begin
            pop_n_s = 2'd0;
        end
    end

    // Entry storage; contents are deliberately left untouched by reset and flush.
    always_ff @(posedge clk) begin
        if (!rst && wr_1_en_s) begin
            mem_r[tail_r] <= '{pc: push_pc_1, inst: push_inst_1};
        end
        if (!rst && wr_2_en_s) begin
            mem_r[wr_2_ptr_s] <= '{pc: push_pc_2, inst: push_inst_2};
        end
    end

    // Pointer and occupancy update: rst over flush over push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_r + PTR_W'(pop_n_s);
            tail_r  <= tail_r + PTR_W'(push_n_s);
            count_r <= count_r + (PTR_W + 1)'(push_n_s) - (PTR_W + 1)'(pop_n_s);
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed testbench for inst_fetch_queue: reset, single pair, fill/backpressure,
// odd push, wrap-around with concurrent push/pop, and flush.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        push_valid_1 = 1'b0;
    logic [31:0] push_pc_1 = 32'h0;
    logic [31:0] push_inst_1 = 32'h0;
    logic        push_valid_2 = 1'b0;
    logic [31:0] push_pc_2 = 32'h0;
    logic [31:0] push_inst_2 = 32'h0;
    logic        id_stall = 1'b0;
    logic        full_o;
    logic        id_valid_1;
    logic [31:0] id_pc_1;
    logic [31:0] id_inst_1;
    logic        id_valid_2;
    logic [31:0] id_pc_2;
    logic [31:0] id_inst_2;

    int tests = 0;
    int fails = 0;

    inst_fetch_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid_1(push_valid_1), .push_pc_1(push_pc_1), .push_inst_1(push_inst_1),
        .push_valid_2(push_valid_2), .push_pc_2(push_pc_2), .push_inst_2(push_inst_2),
        .id_stall(id_stall), .full_o(full_o),
        .id_valid_1(id_valid_1), .id_pc_1(id_pc_1), .id_inst_1(id_inst_1),
        .id_valid_2(id_valid_2), .id_pc_2(id_pc_2), .id_inst_2(id_inst_2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        inst_of = {16'h0280, pc[15:0]} ^ 32'h0000_0c0c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input logic [31:0] pc);
        push_valid_1 = 1'b1; push_pc_1 = pc;         push_inst_1 = inst_of(pc);
        push_valid_2 = 1'b1; push_pc_2 = pc + 32'd4; push_inst_2 = inst_of(pc + 32'd4);
    endtask

    task automatic clear_push();
        push_valid_1 = 1'b0; push_valid_2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_pair(32'h1c00_0f00);
        step();
        step();
        tests++; if (id_valid_1 !== 1'b0) begin fails++; $display("FAIL rst_hold_v1 got %b exp 0", id_valid_1); end
        tests++; if (full_o !== 1'b0) begin fails++; $display("FAIL rst_hold_full got %b exp 0", full_o); end
        rst = 1'b0;
        clear_push();
        step();
        tests++; if (id_valid_1 !== 1'b0) begin fails++; $display("FAIL rst_v1 got %b exp 0", id_valid_1); end
        tests++; if (id_valid_2 !== 1'b0) begin fails++; $display("FAIL rst_v2 got %b exp 0", id_valid_2); end
        tests++; if (full_o !== 1'b0) begin fails++; $display("FAIL rst_full got %b exp 0", full_o); end
        tests++; if (id_pc_1 !== 32'h0) begin fails++; $display("FAIL rst_pc1 got %h exp 0", id_pc_1); end
    endtask

    task automatic test_single_pair();
        id_stall = 1'b0;
        push_valid_1 = 1'b1; push_pc_1 = 32'h1c00_0000; push_inst_1 = 32'h0280_0c0c;
        push_valid_2 = 1'b1; push_pc_2 = 32'h1c00_0004; push_inst_2 = 32'h0280_1010;
        step();
        clear_push();
        tests++; if (id_valid_1 !== 1'b1 || id_valid_2 !== 1'b1) begin fails++; $display("FAIL pair_valid got %b%b exp 11", id_valid_1, id_valid_2); end
        tests++; if (id_pc_1 !== 32'h1c00_0000) begin fails++; $display("FAIL pair_pc1 got %h exp 1c000000", id_pc_1); end
        tests++; if (id_inst_1 !== 32'h0280_0c0c) begin fails++; $display("FAIL pair_inst1 got %h exp 02800c0c", id_inst_1); end
        tests++; if (id_pc_2 !== 32'h1c00_0004) begin fails++; $display("FAIL pair_pc2 got %h exp 1c000004", id_pc_2); end
        tests++; if (id_inst_2 !== 32'h0280_1010) begin fails++; $display("FAIL pair_inst2 got %h exp 02801010", id_inst_2); end
        step();
        tests++; if (id_valid_1 !== 1'b0 || id_valid_2 !== 1'b0) begin fails++; $display("FAIL pair_drain got %b%b exp 00", id_valid_1, id_valid_2); end
        tests++; if (id_pc_2 !== 32'h0) begin fails++; $display("FAIL pair_drain_pc2 got %h exp 0", id_pc_2); end
    endtask

    task automatic test_fill_backpressure();
        logic [31:0] pc;
        id_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_pair(32'h1c00_0000 + 32'(8 * k));
            step();
            tests++; if (full_o !== (k == 3)) begin fails++; $display("FAIL fill_full k=%0d got %b exp %b", k, full_o, (k == 3)); end
            tests++; if (id_pc_1 !== 32'h1c00_0000) begin fails++; $display("FAIL fill_head k=%0d got %h exp 1c000000", k, id_pc_1); end
        end
        set_pair(32'h1c00_0020);
        step();
        tests++; if (full_o !== 1'b1) begin fails++; $display("FAIL fill_ignored_full got %b exp 1", full_o); end
        clear_push();
        id_stall = 1'b0;
        for (int j = 0; j < 4; j++) begin
            pc = 32'h1c00_0000 + 32'(8 * j);
            tests++; if (id_valid_1 !== 1'b1 || id_valid_2 !== 1'b1) begin fails++; $display("FAIL drain_valid j=%0d got %b%b exp 11", j, id_valid_1, id_valid_2); end
            tests++; if (id_pc_1 !== pc) begin fails++; $display("FAIL drain_pc1 j=%0d got %h exp %h", j, id_pc_1, pc); end
            tests++; if (id_pc_2 !== pc + 32'd4) begin fails++; $display("FAIL drain_pc2 j=%0d got %h exp %h", j, id_pc_2, pc + 32'd4); end
            tests++; if (id_inst_2 !== inst_of(pc + 32'd4)) begin fails++; $display("FAIL drain_inst2 j=%0d got %h exp %h", j, id_inst_2, inst_of(pc + 32'd4)); end
            step();
        end
        tests++; if (id_valid_1 !== 1'b0 || full_o !== 1'b0) begin fails++; $display("FAIL drain_empty got v1=%b full=%b exp v1=0 full=0", id_valid_1, full_o); end
    endtask

    task automatic test_odd_push();
        id_stall = 1'b1;
        push_valid_2 = 1'b1; push_pc_2 = 32'h1c00_0014; push_inst_2 = inst_of(32'h1c00_0014);
        step();
        clear_push();
        tests++; if (id_valid_1 !== 1'b1) begin fails++; $display("FAIL odd_v1 got %b exp 1", id_valid_1); end
        tests++; if (id_pc_1 !== 32'h1c00_0014) begin fails++; $display("FAIL odd_pc1 got %h exp 1c000014", id_pc_1); end
        tests++; if (id_inst_1 !== inst_of(32'h1c00_0014)) begin fails++; $display("FAIL odd_inst1 got %h exp %h", id_inst_1, inst_of(32'h1c00_0014)); end
        tests++; if (id_valid_2 !== 1'b0 || id_pc_2 !== 32'h0) begin fails++; $display("FAIL odd_slot2 got v2=%b pc2=%h exp v2=0 pc2=0", id_valid_2, id_pc_2); end
    endtask

    // Continues from the single queued entry left by test_odd_push.
    task automatic test_wrap_push_pop();
        logic [31:0] q[$];
        logic [31:0] nxt;
        logic [31:0] e1;
        logic [31:0] e2;
        int          npop;
        q.push_back(32'h1c00_0014);
        nxt = 32'h1c00_0018;
        id_stall = 1'b0;
        for (int c = 0; c < 16; c++) begin
            e1 = (q.size() >= 1) ? q[0] : 32'h0;
            e2 = (q.size() >= 2) ? q[1] : 32'h0;
            tests++; if (id_valid_1 !== (q.size() >= 1) || id_valid_2 !== (q.size() >= 2)) begin fails++; $display("FAIL wrap_valid c=%0d got %b%b exp %b%b", c, id_valid_1, id_valid_2, (q.size() >= 1), (q.size() >= 2)); end
            tests++; if (id_pc_1 !== e1 || id_pc_2 !== e2) begin fails++; $display("FAIL wrap_pc c=%0d got %h/%h exp %h/%h", c, id_pc_1, id_pc_2, e1, e2); end
            if (q.size() >= 1) begin
                tests++; if (id_inst_1 !== inst_of(e1)) begin fails++; $display("FAIL wrap_inst1 c=%0d got %h exp %h", c, id_inst_1, inst_of(e1)); end
            end
            tests++; if (full_o !== (q.size() > 6)) begin fails++; $display("FAIL wrap_full c=%0d got %b exp %b", c, full_o, (q.size() > 6)); end
            npop = (q.size() >= 2) ? 2 : q.size();
            for (int p = 0; p < npop; p++) void'(q.pop_front());
            if (c < 12) begin
                set_pair(nxt);
                q.push_back(nxt);
                q.push_back(nxt + 32'd4);
                nxt = nxt + 32'd8;
            end else begin
                clear_push();
            end
            step();
        end
        clear_push();
    endtask

    task automatic test_flush();
        id_stall = 1'b1;
        set_pair(32'h1c00_0200);
        step();
        set_pair(32'h1c00_0208);
        step();
        clear_push();
        push_valid_1 = 1'b1; push_pc_1 = 32'h1c00_0210; push_inst_1 = inst_of(32'h1c00_0210);
        step();
        tests++; if (id_valid_2 !== 1'b1 || id_pc_1 !== 32'h1c00_0200) begin fails++; $display("FAIL flush_pre got v2=%b pc1=%h exp v2=1 pc1=1c000200", id_valid_2, id_pc_1); end
        flush = 1'b1;
        push_valid_1 = 1'b1; push_pc_1 = 32'h1c00_0100; push_inst_1 = inst_of(32'h1c00_0100);
        step();
        flush = 1'b0;
        clear_push();
        tests++; if (id_valid_1 !== 1'b0 || id_valid_2 !== 1'b0) begin fails++; $display("FAIL flush_empty got %b%b exp 00", id_valid_1, id_valid_2); end
        tests++; if (full_o !== 1'b0) begin fails++; $display("FAIL flush_full got %b exp 0", full_o); end
        id_stall = 1'b0;
        push_valid_1 = 1'b1; push_pc_1 = 32'h1c00_8000; push_inst_1 = inst_of(32'h1c00_8000);
        step();
        clear_push();
        tests++; if (id_valid_1 !== 1'b1 || id_pc_1 !== 32'h1c00_8000) begin fails++; $display("FAIL flush_refill got v1=%b pc1=%h exp v1=1 pc1=1c008000", id_valid_1, id_pc_1); end
        tests++; if (id_valid_2 !== 1'b0) begin fails++; $display("FAIL flush_refill_v2 got %b exp 0", id_valid_2); end
        step();
        tests++; if (id_valid_1 !== 1'b0) begin fails++; $display("FAIL flush_final got %b exp 0", id_valid_1); end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_fill_backpressure();
        test_odd_push();
        test_wrap_push_pop();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Dual-issue instruction buffer between the PC/fetch stage and decode.
- Each cycle it accepts up to two (pc, inst) pairs from fetch and presents the two oldest entries to decode in program order.
- It drives a backpressure stall back to the PC generator.
- A pipeline flush empties it in one cycle.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥4.
- PTR_W, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high (`RstEnable`)
- flush  input  1  discard all entries and this cycle's push/pop
- push_valid_1  input  1  fetch slot 1 valid
- push_pc_1  input  32  slot 1 PC (`InstAddrBus`)
- push_inst_1  input  32  slot 1 instruction (`InstBus`)
- push_valid_2  input  1  fetch slot 2 valid
- push_pc_2  input  32  slot 2 PC
- push_inst_2  input  32  slot 2 instruction
- id_stall  input  1  decode stall (`Stop`); when high, nothing is popped
- full_o  output  1  fewer than 2 free entries; drives pc_reg stall1/stall2
- id_valid_1  output  1  head entry valid
- id_pc_1  output  32  head PC
- id_inst_1  output  32  head instruction
- id_valid_2  output  1  head+1 entry valid
- id_pc_2  output  32  head+1 PC
- id_inst_2  output  32  head+1 instruction

Behaviour:
- State: circular storage of DEPTH {pc, inst}; head and tail pointers (PTR_W bits, wrap modulo DEPTH); count register (PTR_W+1 bits, range 0..DEPTH).
- Reset (rst=1 at posedge): head=tail=count=0. Storage is not cleared.
  - Outputs during and after reset: full_o=0, id_valid_1=id_valid_2=0, id_pc_*=0, id_inst_*=0.
- Priority: rst > flush > push/pop.
- Flush: next cycle head=tail=count=0, all outputs invalid. Any push or pop in the flush cycle is dropped.
- full_o: combinational, equals (count > DEPTH-2).
- Push:
  - Accepted only when full_o=0; when full_o=1 all push inputs are ignored and no entry is lost.
  - Accepted valid slots are written at tail in order slot 1 then slot 2; tail and count advance by 0, 1 or 2.
  - push_valid_2 alone (misaligned target) writes one entry at tail.
  - Valid slots are compacted: no hole is left for an invalid slot 1.
- Outputs: combinational from storage at head and head+1 (mod DEPTH).
  - id_valid_1 = (count≥1); id_valid_2 = (count≥2).
  - Any invalid slot drives pc=0, inst=0.
- Pop: when id_stall=0 and flush=0, pop_n = id_valid_1 + id_valid_2, and head advances by pop_n. Decode consumes every valid output slot.
- Latency: an entry pushed at edge N is visible on the id_* outputs after edge N, i.e. during cycle N+1. There is no bypass from push to outputs in the same cycle.
- Simultaneous push and pop is legal: count_next = count + push_n − pop_n. full_o uses current count, not count_next.
- Pointer arithmetic wraps at DEPTH-1 → 0. head+1 wraps likewise.
- Overflow and underflow cannot occur by construction. Verification asserts count ≤ DEPTH and that head−tail agrees with count.

Decomposition:
- Shared defines: `RegBus`, `InstAddrBus`, `InstBus`, `RstEnable`, `Stop`, `ChipDisable` stay in defines.v.
- Add `IfqDepth` (8) to defines.v.
- No sub-module: storage, pointers and count fit in one module. The entry {pc, inst} is a 64-bit packed word.

Test Plan:
- Reset: hold rst=1 for 2 cycles with push_valid_1=push_valid_2=1 → id_valid_1=id_valid_2=0, full_o=0, count=0 after release.
- Single pair: push pc 0x1c000000/0x1c000004, inst 0x02800c0c/0x02801010, id_stall=0.
  - Next cycle both id_valid=1 with those values.
  - Cycle after, both invalid.
- Fill/backpressure: id_stall=1; push pairs 0x1c000000…0x1c00001c.
  - After 3 pairs count=6, full_o=0.
  - After 4th pair count=8, full_o=1.
  - 5th pair (0x1c000020) ignored.
  - Release stall → pops return 0x1c000000..0x1c00001c in order, 2 per cycle.
- Odd single push: push_valid_2 only, pc 0x1c000014, id_stall=1 → next cycle id_valid_1=1, id_pc_1=0x1c000014, id_valid_2=0.
- Wrap-around and push/pop: sustain push pair and pop pair for 12 cycles with odd-length prefix (single push first) → PC order strictly +4, pointers wrap, count constant.
- Flush: with 5 entries queued and a push of 0x1c000100 in the flush cycle.
  - Next cycle empty and full_o=0.
  - Then push 0x1c008000 → appears as id_pc_1 the following cycle.
